// File: rtl/pid_pkg.sv
// Shared constants and helpers for the steering PID: coefficients, clamp limits
// and forward-ramp tuning.
package pid_pkg;

  typedef logic signed [13:0] term_t;

  localparam term_t            P_COEFF        = 14'sd8;
  localparam term_t            D_COEFF        = 14'sd11;
  localparam logic [10:0]      MAX_FRWRD      = 11'h300;
  localparam logic signed [15:0] ERR_MAX      = 16'sd511;
  localparam logic signed [15:0] ERR_MIN      = -16'sd512;
  localparam logic signed [10:0] D_MAX        = 11'sd63;
  localparam logic signed [10:0] D_MIN        = -11'sd64;
  localparam logic [10:0]      FRWRD_INC_SLOW = 11'd1;
  localparam logic [10:0]      FRWRD_INC_FAST = 11'd4;

  // Motor duty is unsigned 11 bits; negative requests floor at zero.
  function automatic logic [10:0] clamp_spd(input logic signed [12:0] v);
    if (v < 13'sd0)
      return 11'd0;
    else if (v > 13'sd2047)
      return 11'h7FF;
    else
      return v[10:0];
  endfunction

endpackage

// File: rtl/frwrd_ramp.sv
// Saturating forward-speed ramp; advances once per accepted error sample and
// drops to zero whenever motion is disabled.
module frwrd_ramp
  import pid_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_go,
  input  logic        i_inc,
  output logic [10:0] o_frwrd
);

  localparam logic [10:0] STEP = FAST_SIM ? FRWRD_INC_FAST : FRWRD_INC_SLOW;

  logic [10:0] r_frwrd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_frwrd <= '0;
    else if (!i_go)
      r_frwrd <= '0;
    else if (i_inc)
      r_frwrd <= (r_frwrd >= MAX_FRWRD - STEP) ? MAX_FRWRD : r_frwrd + STEP;
  end

  assign o_frwrd = r_frwrd;

endmodule

// File: rtl/steer_pid.sv
// Two-stage steering PID: stage 1 registers the P/I/D terms and ramp, stage 2
// mixes the PID correction into left/right motor duties.
module steer_pid
  import pid_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] error,
  input  logic               err_vld,
  input  logic               go,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rght_spd,
  output logic               pid_vld
);

  logic               w_accept;
  logic signed [9:0]  w_err_sat;
  term_t              w_err_ext;
  term_t              w_p_term;
  term_t              w_i_term;
  term_t              w_d_term;
  logic signed [16:0] w_integ_sum;
  logic signed [15:0] w_integ_next;
  logic signed [10:0] w_d_raw;
  logic signed [10:0] w_d_sat;
  logic [10:0]        w_frwrd;
  term_t              w_pid;
  term_t              w_pid_shft;
  logic signed [12:0] w_lft_sum;
  logic signed [12:0] w_rght_sum;

  logic signed [15:0] r_integ;
  logic signed [9:0]  r_prev_err;
  term_t              r_p_term;
  term_t              r_i_term;
  term_t              r_d_term;
  logic               r_vld1;

  assign w_accept = err_vld & go;

  always_comb begin
    w_err_sat = error[9:0];
    if (error > ERR_MAX)
      w_err_sat = ERR_MAX[9:0];
    else if (error < ERR_MIN)
      w_err_sat = ERR_MIN[9:0];
  end

  assign w_err_ext = {{4{w_err_sat[9]}}, w_err_sat};
  assign w_p_term  = w_err_ext * P_COEFF;

  // 17-bit sum: a disagreement between the top two bits means 16-bit overflow.
  assign w_integ_sum  = {r_integ[15], r_integ} + {{7{w_err_sat[9]}}, w_err_sat};
  assign w_integ_next = (w_integ_sum[16] != w_integ_sum[15])
                      ? (w_integ_sum[16] ? 16'sh8000 : 16'sh7FFF)
                      : w_integ_sum[15:0];
  assign w_i_term     = {{2{r_integ[15]}}, r_integ[15:4]};

  assign w_d_raw = {w_err_sat[9], w_err_sat} - {r_prev_err[9], r_prev_err};

  always_comb begin
    w_d_sat = w_d_raw;
    if (w_d_raw > D_MAX)
      w_d_sat = D_MAX;
    else if (w_d_raw < D_MIN)
      w_d_sat = D_MIN;
  end

  assign w_d_term = {{3{w_d_sat[10]}}, w_d_sat} * D_COEFF;

  frwrd_ramp #(
    .FAST_SIM (FAST_SIM)
  ) u_frwrd_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_go    (go),
    .i_inc   (w_accept),
    .o_frwrd (w_frwrd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_integ    <= '0;
      r_prev_err <= '0;
      r_p_term   <= '0;
      r_i_term   <= '0;
      r_d_term   <= '0;
      r_vld1     <= 1'b0;
    end else if (!go) begin
      r_integ    <= '0;
      r_prev_err <= '0;
      r_p_term   <= '0;
      r_i_term   <= '0;
      r_d_term   <= '0;
      r_vld1     <= 1'b0;
    end else begin
      r_vld1 <= err_vld;
      if (err_vld) begin
        r_integ    <= w_integ_next;
        r_prev_err <= w_err_sat;
        r_p_term   <= w_p_term;
        r_i_term   <= w_i_term;
        r_d_term   <= w_d_term;
      end
    end
  end

  // The ramp register already holds the post-increment value by stage 2.
  assign w_pid      = r_p_term + r_i_term + r_d_term;
  assign w_pid_shft = w_pid >>> 3;
  assign w_lft_sum  = 13'({3'b000, w_frwrd} + w_pid_shft);
  assign w_rght_sum = 13'({3'b000, w_frwrd} - w_pid_shft);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      pid_vld  <= 1'b0;
    end else if (!go) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      pid_vld  <= 1'b0;
    end else begin
      pid_vld <= r_vld1;
      if (r_vld1) begin
        lft_spd  <= clamp_spd(w_lft_sum);
        rght_spd <= clamp_spd(w_rght_sum);
      end
    end
  end

endmodule

// File: tb/tb_steer_pid.sv
// Directed bench for steer_pid: hand-computed duty values for saturation,
// integrator clamping, ramp limits, go-drop and asynchronous reset.
module tb_steer_pid;

  logic        clk;
  logic        rst_n;
  logic [15:0] error;
  logic        err_vld;
  logic        go;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        pid_vld;
  logic [10:0] lft_f;
  logic [10:0] rght_f;
  logic        vld_f;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  steer_pid #(.FAST_SIM(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .error    (error),
    .err_vld  (err_vld),
    .go       (go),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .pid_vld  (pid_vld)
  );

  steer_pid #(.FAST_SIM(1'b1)) dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .error    (error),
    .err_vld  (err_vld),
    .go       (go),
    .lft_spd  (lft_f),
    .rght_spd (rght_f),
    .pid_vld  (vld_f)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s observed=%0d expected=%0d ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated sample; returns once its result is on the outputs.
  task automatic pulse(input logic [15:0] e);
    error   = e;
    err_vld = 1'b1;
    step();
    err_vld = 1'b0;
    step();
  endtask

  task automatic clear_go();
    go = 1'b0;
    step();
    go = 1'b1;
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    go      = 1'b0;
    error   = '0;
    err_vld = 1'b0;

    #3;
    chk("reset_lft", lft_spd, 0);
    chk("reset_rght", rght_spd, 0);
    chk("reset_vld", pid_vld, 0);

    // First sample after reset, go rising together with err_vld
    @(negedge clk);
    rst_n   = 1'b1;
    go      = 1'b1;
    error   = 16'h0340;
    err_vld = 1'b1;
    step();
    err_vld = 1'b0;
    chk("first_vld_lat1", pid_vld, 0);
    step();
    chk("first_vld_lat2", pid_vld, 1);
    chk("first_lft", lft_spd, 598);
    chk("first_rght", rght_spd, 0);
    step();
    chk("first_vld_strobe", pid_vld, 0);
    chk("first_lft_hold", lft_spd, 598);

    // Small-signal pattern incl. negative error and integrator pickup
    clear_go();
    pulse(16'd10);
    chk("small1_lft", lft_spd, 24);
    chk("small1_rght", rght_spd, 0);
    pulse(16'd10);
    chk("small2_lft", lft_spd, 12);
    pulse(16'hFFEC);
    chk("small3_lft", lft_spd, 0);
    chk("small3_rght", rght_spd, 65);

    // go dropped one clock after err_vld discards the in-flight sample
    error   = 16'd100;
    err_vld = 1'b1;
    step();
    err_vld = 1'b0;
    go      = 1'b0;
    step();
    chk("godrop_vld", pid_vld, 0);
    chk("godrop_lft", lft_spd, 0);
    chk("godrop_rght", rght_spd, 0);
    step();
    chk("godrop_vld_late", pid_vld, 0);
    go      = 1'b1;
    error   = 16'h0340;
    err_vld = 1'b1;
    step();
    err_vld = 1'b0;
    step();
    chk("regrow_vld", pid_vld, 1);
    chk("regrow_lft", lft_spd, 598);
    chk("regrow_rght", rght_spd, 0);

    // err_vld while go=0 is ignored
    go      = 1'b0;
    err_vld = 1'b1;
    step();
    step();
    err_vld = 1'b0;
    chk("nogo_vld", pid_vld, 0);
    chk("nogo_lft", lft_spd, 0);
    step();
    chk("nogo_vld_late", pid_vld, 0);

    // Consecutive samples with zero error: pure forward ramp
    go      = 1'b1;
    error   = 16'd0;
    err_vld = 1'b1;
    for (int i = 1; i <= 768; i++) begin
      step();
      if (i == 2) begin
        chk("ramp_vld_first", pid_vld, 1);
        chk("ramp_lft_first", lft_spd, 1);
      end
      if (i == 100) begin
        chk("ramp_lft_99", lft_spd, 99);
        chk("ramp_rght_99", rght_spd, 99);
        chk("ramp_fast_99", lft_f, 396);
        chk("ramp_vld_b2b", pid_vld, 1);
      end
      if (i == 192) chk("fast_191", lft_f, 11'h2FC);
      if (i == 193) begin
        chk("fast_192_lft", lft_f, 11'h300);
        chk("fast_192_rght", rght_f, 11'h300);
      end
    end
    err_vld = 1'b0;
    step();
    chk("ramp_max_lft", lft_spd, 11'h300);
    chk("ramp_max_rght", rght_spd, 11'h300);
    chk("ramp_max_vld", pid_vld, 1);
    err_vld = 1'b1;
    repeat (10) step();
    err_vld = 1'b0;
    step();
    chk("ramp_sat_lft", lft_spd, 11'h300);
    chk("ramp_sat_rght", rght_spd, 11'h300);

    // Sustained +511: integrator clamps at 0x7FFF after pulse 65
    clear_go();
    for (int n = 1; n <= 70; n++) begin
      pulse(16'h01FF);
      if (n == 1)  chk("ipos_p1", lft_spd, 598);
      if (n == 65) chk("ipos_p65", lft_spd, 831);
      if (n == 66) chk("ipos_p66", lft_spd, 832);
      if (n == 70) begin
        chk("ipos_p70_lft", lft_spd, 836);
        chk("ipos_p70_rght", rght_spd, 0);
      end
    end

    // Sustained 0x8000: input clamps to -512, integrator clamps at 0x8000
    clear_go();
    for (int n = 1; n <= 70; n++) begin
      pulse(16'h8000);
      if (n == 1) begin
        chk("ineg_p1_lft", lft_spd, 0);
        chk("ineg_p1_rght", rght_spd, 601);
      end
      if (n == 66) chk("ineg_p66", rght_spd, 834);
      if (n == 70) chk("ineg_p70", rght_spd, 838);
    end

    // Asynchronous reset mid-ramp
    clear_go();
    error   = 16'd0;
    err_vld = 1'b1;
    repeat (288) step();
    err_vld = 1'b0;
    step();
    chk("midramp_lft", lft_spd, 11'h120);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lft", lft_spd, 0);
    chk("async_rst_rght", rght_spd, 0);
    chk("async_rst_fast", lft_f, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(16'd0);
    chk("restart_lft", lft_spd, 1);
    chk("restart_rght", rght_spd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
